// File: rtl/load_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_unit
//  Description : Multi-cycle handshaked load unit. Accepts one load from EX,
//                issues aligned reads on a grant/rvalid port, splits
//                boundary-crossing loads into two reads, then extracts and
//                sign/zero-extends the addressed bytes for register write-back.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_unit #(
    parameter int XLEN        = 32,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_valid_i,
    output logic            ld_ready_o,
    input  logic [XLEN-1:0] ld_addr_i,
    input  logic [1:0]      ld_size_i,
    input  logic            ld_sign_ext_i,
    input  logic [4:0]      ld_rd_i,
    input  logic            flush_i,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            wb_valid_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            wb_misalign_o
);

    localparam int              NB           = XLEN / 8;
    localparam int              OW           = $clog2(NB);
    localparam logic [XLEN-1:0] C_ALIGN_MASK = ~XLEN'(NB - 1);
    localparam logic [XLEN-1:0] C_WORD_BYTES = XLEN'(NB);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ0  = 3'd1;
    localparam logic [2:0] S_WAIT0 = 3'd2;
    localparam logic [2:0] S_REQ1  = 3'd3;
    localparam logic [2:0] S_WAIT1 = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;
    localparam logic [2:0] S_FAULT = 3'd6;
    localparam logic [2:0] S_DRAIN = 3'd7;

    logic [2:0]      state_q, state_d;
    logic [OW-1:0]   off_q, off_d;
    logic [1:0]      size_q, size_d;
    logic            sign_q, sign_d;
    logic [4:0]      rd_q, rd_d;
    logic            split_q, split_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [4:0]      wb_rd_q, wb_rd_d;

    logic            w_accept;
    logic [OW-1:0]   w_off;
    logic [3:0]      w_nbytes;
    logic [2:0]      w_mask;
    logic            w_fault;
    logic            w_split;
    logic [XLEN-1:0] w_lo;
    logic [XLEN-1:0] w_hi;
    logic [XLEN-1:0] w_raw;
    logic [XLEN-1:0] w_keep;
    logic            w_msb;
    logic [XLEN-1:0] w_ext;

    // A flush in IDLE blocks acceptance even though ready is high
    assign w_accept = (state_q == S_IDLE) && ld_valid_i && !flush_i;
    assign w_off    = ld_addr_i[OW-1:0];

    // Classify the incoming request: byte count, alignment fault, bus-word split
    always_comb begin
        w_nbytes = 4'd1;
        w_mask   = 3'd0;
        unique case (ld_size_i)
            2'd0:    begin w_nbytes = 4'd1; w_mask = 3'd0; end
            2'd1:    begin w_nbytes = 4'd2; w_mask = 3'd1; end
            2'd2:    begin w_nbytes = 4'd4; w_mask = 3'd3; end
            default: begin w_nbytes = 4'd8; w_mask = 3'd7; end
        endcase
        w_fault = ((ld_size_i == 2'd3) && (XLEN == 32)) ||
                  (!MISALIGN_EN && ((ld_addr_i[2:0] & w_mask) != 3'd0));
        w_split = MISALIGN_EN && ((5'(w_off) + 5'(w_nbytes)) > 5'(NB));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; flush outranks everything but reset, and a flush that
    // leaves a read in flight parks in DRAIN to swallow its rvalid
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (w_accept) state_d = w_fault ? S_FAULT : S_REQ0;
            end
            S_REQ0: begin
                if (flush_i)        state_d = mem_gnt_i ? S_DRAIN : S_IDLE;
                else if (mem_gnt_i) state_d = S_WAIT0;
            end
            S_WAIT0: begin
                if (mem_rvalid_i)   state_d = flush_i ? S_IDLE : (split_q ? S_REQ1 : S_RESP);
                else if (flush_i)   state_d = S_DRAIN;
            end
            S_REQ1: begin
                if (flush_i)        state_d = mem_gnt_i ? S_DRAIN : S_IDLE;
                else if (mem_gnt_i) state_d = S_WAIT1;
            end
            S_WAIT1: begin
                if (mem_rvalid_i)   state_d = flush_i ? S_IDLE : S_RESP;
                else if (flush_i)   state_d = S_DRAIN;
            end
            S_RESP:  state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            S_DRAIN: begin
                if (mem_rvalid_i)   state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control outputs decoded straight from the state register
    always_comb begin
        ld_ready_o    = (state_q == S_IDLE);
        mem_req_o     = (state_q == S_REQ0) || (state_q == S_REQ1);
        wb_valid_o    = (state_q == S_RESP) || (state_q == S_FAULT);
        wb_misalign_o = (state_q == S_FAULT);
    end

    // Extract and extend; the final read word is taken straight off the bus
    // so the result can be registered on the same edge it arrives
    always_comb begin
        w_lo   = (state_q == S_WAIT0) ? mem_rdata_i : lo_q;
        w_hi   = (state_q == S_WAIT1) ? mem_rdata_i : '0;
        w_raw  = XLEN'({w_hi, w_lo} >> {off_q, 3'b000});
        w_keep = '1;
        w_msb  = 1'b0;
        unique case (size_q)
            2'd0:    begin w_keep = XLEN'(64'hFF);        w_msb = w_raw[7];      end
            2'd1:    begin w_keep = XLEN'(64'hFFFF);      w_msb = w_raw[15];     end
            2'd2:    begin w_keep = XLEN'(64'hFFFF_FFFF); w_msb = w_raw[31];     end
            default: begin w_keep = '1;                   w_msb = w_raw[XLEN-1]; end
        endcase
        w_ext = (w_raw & w_keep) | ((sign_q && w_msb) ? ~w_keep : '0);
    end

    // Datapath next values: capture on accept, collect read data, load results
    always_comb begin
        off_d      = off_q;
        size_d     = size_q;
        sign_d     = sign_q;
        rd_d       = rd_q;
        split_d    = split_q;
        lo_d       = lo_q;
        mem_addr_d = mem_addr_q;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        if (w_accept) begin
            off_d   = w_off;
            size_d  = ld_size_i;
            sign_d  = ld_sign_ext_i;
            rd_d    = ld_rd_i;
            split_d = w_split;
            if (!w_fault) mem_addr_d = ld_addr_i & C_ALIGN_MASK;
        end
        if ((state_q == S_WAIT0) && mem_rvalid_i) lo_d = mem_rdata_i;
        if ((state_q == S_WAIT0) && (state_d == S_REQ1)) mem_addr_d = mem_addr_q + C_WORD_BYTES;
        if (state_d == S_RESP) begin
            wb_data_d = w_ext;
            wb_rd_d   = rd_q;
        end
        if (state_d == S_FAULT) begin
            wb_data_d = '0;
            wb_rd_d   = ld_rd_i;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            off_q      <= '0;
            size_q     <= 2'd0;
            sign_q     <= 1'b0;
            rd_q       <= 5'd0;
            split_q    <= 1'b0;
            lo_q       <= '0;
            mem_addr_q <= '0;
            wb_data_q  <= '0;
            wb_rd_q    <= 5'd0;
        end else begin
            off_q      <= off_d;
            size_q     <= size_d;
            sign_q     <= sign_d;
            rd_q       <= rd_d;
            split_q    <= split_d;
            lo_q       <= lo_d;
            mem_addr_q <= mem_addr_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
        end
    end

    assign mem_addr_o = mem_addr_q;
    assign wb_data_o  = wb_data_q;
    assign wb_rd_o    = wb_rd_q;

endmodule
`default_nettype wire
